periph_bus_initiator: RTL and testbench

PERIPH_BUS_INITIATOR -- requirements
Module: periph_bus_initiator

---
 rtl/periph_bus_initiator_if.sv | 29 ++
 rtl/periph_bus_initiator.sv | 140 ++++++++++++++
 tb/tb_periph_bus_initiator.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_initiator_if.sv
// rtl/periph_bus_initiator_if.sv - periph bus request/response signal bundle
// master = initiator side, slave = target side.
interface periph_bus_initiator_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 2
);
   logic                    req_o;
   logic [ADDR_WIDTH-1:0]   add_o;
   logic                    wen_o;
   logic [DATA_WIDTH-1:0]   wdata_o;
   logic [DATA_WIDTH/8-1:0] be_o;
   logic [ID_WIDTH-1:0]     id_o;
   logic                    gnt_i;
   logic                    r_valid_i;
   logic                    r_opc_i;
   logic [ID_WIDTH-1:0]     r_id_i;
   logic [DATA_WIDTH-1:0]   r_rdata_i;

   modport master (
      output req_o, add_o, wen_o, wdata_o, be_o, id_o,
      input  gnt_i, r_valid_i, r_opc_i, r_id_i, r_rdata_i
   );

   modport slave (
      input  req_o, add_o, wen_o, wdata_o, be_o, id_o,
      output gnt_i, r_valid_i, r_opc_i, r_id_i, r_rdata_i
   );
endinterface

// File: rtl/periph_bus_initiator.sv
// rtl/periph_bus_initiator.sv - credit-limited periph bus initiator
// One request register stage toward the bus, response FIFO toward the consumer.
module periph_bus_initiator #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int ID_WIDTH        = 2,
   parameter int ID              = 0,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic                                       cmd_valid_i,
   output logic                                       cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0]                      cmd_addr_i,
   input  logic                                       cmd_wen_i,
   input  logic [DATA_WIDTH-1:0]                      cmd_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]                    cmd_be_i,
   periph_bus_initiator_if.master                     bus,
   output logic                                       rsp_valid_o,
   input  logic                                       rsp_ready_i,
   output logic [DATA_WIDTH-1:0]                      rsp_rdata_o,
   output logic                                       rsp_err_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
   output logic                                       busy_o
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

   typedef enum logic {S_IDLE, S_REQ} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  wen_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [BE_W-1:0]       be_q;
   logic [CNT_W-1:0]      outstanding_q, outstanding_d;

   logic [DATA_WIDTH:0]   fifo_mem_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      fifo_cnt_q;

   logic cmd_accept, push_req, push, rsp_pop, fifo_full, fifo_empty;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Grant frees the request register in the same cycle, so a new command can replace it.
   assign cmd_ready_o = ((state_q == S_IDLE) || bus.gnt_i) && (outstanding_q < MAX_CNT);
   assign cmd_accept  = cmd_valid_i && cmd_ready_o;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cmd_accept) state_d = S_REQ;
         S_REQ:   if (bus.gnt_i && !cmd_accept) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         if (cmd_accept) begin
            addr_q  <= cmd_addr_i;
            wen_q   <= cmd_wen_i;
            wdata_q <= cmd_wdata_i;
            be_q    <= cmd_be_i;
         end
      end
   end

   assign bus.req_o   = (state_q == S_REQ);
   assign bus.add_o   = addr_q;
   assign bus.wen_o   = wen_q;
   assign bus.wdata_o = wdata_q;
   assign bus.be_o    = be_q;
   assign bus.id_o    = ID_WIDTH'(ID);

   // Decrement is guarded so an unsolicited response cannot wrap the counter below zero.
   always_comb begin
      outstanding_d = outstanding_q;
      case ({cmd_accept, rsp_pop})
         2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
         2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - CNT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) outstanding_q <= '0;
      else         outstanding_q <= outstanding_d;
   end

   assign push_req   = bus.r_valid_i && (bus.r_id_i == ID_WIDTH'(ID));
   assign fifo_full  = (fifo_cnt_q == MAX_CNT);
   assign fifo_empty = (fifo_cnt_q == '0);
   assign rsp_pop    = !fifo_empty && rsp_ready_i;
   assign push       = push_req && (!fifo_full || rsp_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_mem_q[i] <= '0;
      end else begin
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= {bus.r_rdata_i, bus.r_opc_i};
            wr_ptr_q             <= ptr_inc(wr_ptr_q);
         end
         if (rsp_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, rsp_pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   assign rsp_valid_o   = !fifo_empty;
   assign rsp_rdata_o   = fifo_mem_q[rd_ptr_q][DATA_WIDTH:1];
   assign rsp_err_o     = fifo_mem_q[rd_ptr_q][0];
   assign outstanding_o = outstanding_q;
   assign busy_o        = bus.req_o || (outstanding_q != '0);

   // A compliant slave never returns more responses than credits handed out.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_req && fifo_full && !rsp_pop))
      else $error("periph_bus_initiator: response pushed into full FIFO, dropped");
endmodule

// File: tb/tb_periph_bus_initiator.sv
// tb/tb_periph_bus_initiator.sv - directed self-checking bench for periph_bus_initiator
module tb_periph_bus_initiator;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [31:0] cmd_addr_i = '0;
   logic        cmd_wen_i = 1'b0;
   logic [31:0] cmd_wdata_i = '0;
   logic [3:0]  cmd_be_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic [1:0]  outstanding_o;
   logic        busy_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   periph_bus_initiator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2)) bus_if ();

   periph_bus_initiator #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2), .ID(0), .MAX_OUTSTANDING(2)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
      .cmd_wen_i(cmd_wen_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
      .bus(bus_if),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .outstanding_o(outstanding_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic cmd(input logic v, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] be);
      cmd_valid_i = v; cmd_addr_i = a; cmd_wen_i = w; cmd_wdata_i = d; cmd_be_i = be;
   endtask

   task automatic rsp(input logic v, input logic [1:0] id, input logic opc, input logic [31:0] d);
      bus_if.r_valid_i = v; bus_if.r_id_i = id; bus_if.r_opc_i = opc; bus_if.r_rdata_i = d;
   endtask

   initial begin
      bus_if.gnt_i = 1'b0;
      rsp(1'b0, 2'd0, 1'b0, 32'h0);
      #2;
      chk("rst_req", bus_if.req_o, 1'b0);
      chk("rst_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_outstanding", outstanding_o, 2'd0);
      chk("rst_cmd_ready", cmd_ready_o, 1'b1);
      chk("rst_add", bus_if.add_o, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // single write
      next_cycle();
      cmd(1'b1, 32'h10, 1'b0, 32'hDEADBEEF, 4'hF);
      settle();
      chk("w_ready", cmd_ready_o, 1'b1);
      chk("w_req_before", bus_if.req_o, 1'b0);
      next_cycle();
      cmd(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      bus_if.gnt_i = 1'b1;
      settle();
      chk("w_req", bus_if.req_o, 1'b1);
      chk("w_add", bus_if.add_o, 32'h10);
      chk("w_wdata", bus_if.wdata_o, 32'hDEADBEEF);
      chk("w_be", bus_if.be_o, 4'hF);
      chk("w_wen", bus_if.wen_o, 1'b0);
      chk("w_id", bus_if.id_o, 2'd0);
      chk("w_out1", outstanding_o, 2'd1);
      next_cycle();
      bus_if.gnt_i = 1'b0;
      rsp(1'b1, 2'd0, 1'b0, 32'h0);
      settle();
      chk("w_req_1cyc", bus_if.req_o, 1'b0);
      chk("w_no_comb_rsp", rsp_valid_o, 1'b0);
      next_cycle();
      rsp(1'b0, 2'd0, 1'b0, 32'h0);
      settle();
      chk("w_rsp_valid", rsp_valid_o, 1'b1);
      chk("w_rsp_err", rsp_err_o, 1'b0);
      chk("w_busy", busy_o, 1'b1);
      rsp_ready_i = 1'b1;
      next_cycle();
      rsp_ready_i = 1'b0;
      settle();
      chk("w_popped", rsp_valid_o, 1'b0);
      chk("w_out0", outstanding_o, 2'd0);
      chk("w_idle", busy_o, 1'b0);

      // read with grant held off for 3 cycles
      next_cycle();
      cmd(1'b1, 32'h20, 1'b1, 32'h0, 4'hF);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         cmd(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
         settle();
         chk("r_req_hold", bus_if.req_o, 1'b1);
         chk("r_add_hold", bus_if.add_o, 32'h20);
         chk("r_ready_blk", cmd_ready_o, 1'b0);
      end
      next_cycle();
      bus_if.gnt_i = 1'b1;
      settle();
      chk("r_req_4th", bus_if.req_o, 1'b1);
      chk("r_wen", bus_if.wen_o, 1'b1);
      chk("r_ready_gnt", cmd_ready_o, 1'b1);
      next_cycle();
      bus_if.gnt_i = 1'b0;
      rsp(1'b1, 2'd0, 1'b0, 32'h12345678);
      settle();
      chk("r_req_drop", bus_if.req_o, 1'b0);
      next_cycle();
      rsp(1'b0, 2'd0, 1'b0, 32'h0);
      settle();
      chk("r_rsp_valid", rsp_valid_o, 1'b1);
      chk("r_rdata", rsp_rdata_o, 32'h12345678);
      rsp_ready_i = 1'b1;
      next_cycle();
      rsp_ready_i = 1'b0;
      settle();
      chk("r_out0", outstanding_o, 2'd0);

      // credit limit, back-to-back issue, error response, foreign ID
      next_cycle();
      cmd(1'b1, 32'h100, 1'b0, 32'h1, 4'h1);
      next_cycle();
      cmd(1'b1, 32'h104, 1'b0, 32'h2, 4'h2);
      bus_if.gnt_i = 1'b1;
      settle();
      chk("c_ready_b2b", cmd_ready_o, 1'b1);
      chk("c_addA", bus_if.add_o, 32'h100);
      next_cycle();
      cmd(1'b1, 32'h108, 1'b0, 32'h3, 4'h4);
      settle();
      chk("c_req_nobubble", bus_if.req_o, 1'b1);
      chk("c_addB", bus_if.add_o, 32'h104);
      chk("c_out2", outstanding_o, 2'd2);
      chk("c_ready_full", cmd_ready_o, 1'b0);
      next_cycle();
      bus_if.gnt_i = 1'b0;
      rsp(1'b1, 2'd0, 1'b0, 32'hA1);
      settle();
      chk("c_req_idle", bus_if.req_o, 1'b0);
      chk("c_ready_full2", cmd_ready_o, 1'b0);
      next_cycle();
      rsp(1'b1, 2'd0, 1'b1, 32'hB2);
      settle();
      chk("c_headA", rsp_rdata_o, 32'hA1);
      chk("c_errA", rsp_err_o, 1'b0);
      next_cycle();
      rsp(1'b0, 2'd0, 1'b0, 32'h0);
      settle();
      chk("c_headA_still", rsp_rdata_o, 32'hA1);
      chk("c_out2_hold", outstanding_o, 2'd2);
      rsp_ready_i = 1'b1;
      next_cycle();
      settle();
      chk("c_headB", rsp_rdata_o, 32'hB2);
      chk("c_errB", rsp_err_o, 1'b1);
      chk("c_out1", outstanding_o, 2'd1);
      chk("c_ready_third", cmd_ready_o, 1'b1);
      next_cycle();
      rsp_ready_i = 1'b0;
      cmd(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      bus_if.gnt_i = 1'b1;
      settle();
      chk("c_acc_pop_out", outstanding_o, 2'd1);
      chk("c_addC", bus_if.add_o, 32'h108);
      chk("c_fifo_empty", rsp_valid_o, 1'b0);
      next_cycle();
      bus_if.gnt_i = 1'b0;
      rsp(1'b1, 2'd0, 1'b0, 32'hC3);
      next_cycle();
      rsp(1'b1, 2'd2, 1'b0, 32'hEE);
      settle();
      chk("c_headC", rsp_rdata_o, 32'hC3);
      next_cycle();
      rsp(1'b0, 2'd0, 1'b0, 32'h0);
      settle();
      chk("c_foreign_head", rsp_rdata_o, 32'hC3);
      chk("c_foreign_out", outstanding_o, 2'd1);
      rsp_ready_i = 1'b1;
      next_cycle();
      rsp_ready_i = 1'b0;
      settle();
      chk("c_foreign_nopush", rsp_valid_o, 1'b0);
      chk("c_out0", outstanding_o, 2'd0);

      // push and pop in the same cycle with one entry buffered
      next_cycle();
      cmd(1'b1, 32'h200, 1'b0, 32'h0, 4'hF);
      next_cycle();
      cmd(1'b1, 32'h204, 1'b0, 32'h0, 4'hF);
      bus_if.gnt_i = 1'b1;
      next_cycle();
      cmd(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      rsp(1'b1, 2'd0, 1'b0, 32'hD1);
      settle();
      chk("p_addE", bus_if.add_o, 32'h204);
      next_cycle();
      bus_if.gnt_i = 1'b0;
      rsp(1'b1, 2'd0, 1'b0, 32'hE2);
      rsp_ready_i = 1'b1;
      settle();
      chk("p_headD", rsp_rdata_o, 32'hD1);
      next_cycle();
      rsp(1'b0, 2'd0, 1'b0, 32'h0);
      settle();
      chk("p_valid", rsp_valid_o, 1'b1);
      chk("p_headE", rsp_rdata_o, 32'hE2);
      chk("p_out1", outstanding_o, 2'd1);
      next_cycle();
      rsp_ready_i = 1'b0;
      settle();
      chk("p_one_entry", rsp_valid_o, 1'b0);
      chk("p_out0", outstanding_o, 2'd0);

      // reset with a pending request and a buffered response
      next_cycle();
      cmd(1'b1, 32'h300, 1'b0, 32'h0, 4'hF);
      next_cycle();
      cmd(1'b1, 32'h304, 1'b0, 32'h0, 4'hF);
      bus_if.gnt_i = 1'b1;
      next_cycle();
      cmd(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      bus_if.gnt_i = 1'b0;
      rsp(1'b1, 2'd0, 1'b0, 32'h77);
      next_cycle();
      rsp(1'b0, 2'd0, 1'b0, 32'h0);
      settle();
      chk("x_req_pre", bus_if.req_o, 1'b1);
      chk("x_rsp_pre", rsp_valid_o, 1'b1);
      chk("x_out_pre", outstanding_o, 2'd2);
      rst_ni = 1'b0;
      #1;
      chk("x_req", bus_if.req_o, 1'b0);
      chk("x_rsp", rsp_valid_o, 1'b0);
      chk("x_out", outstanding_o, 2'd0);
      chk("x_busy", busy_o, 1'b0);
      chk("x_ready", cmd_ready_o, 1'b1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      next_cycle();
      cmd(1'b1, 32'h400, 1'b0, 32'h5, 4'hF);
      settle();
      chk("x_fresh_req", bus_if.req_o, 1'b0);
      next_cycle();
      cmd(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      settle();
      chk("x_fresh_add", bus_if.add_o, 32'h400);
      chk("x_fresh_out", outstanding_o, 2'd1);
      chk("x_fresh_rsp", rsp_valid_o, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
